// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared opcodes, FSM state encoding, ALU op codes and instruction classes
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;
  typedef enum logic [2:0] {CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_NONE} op_class_t;
endpackage

// File: rtl/ctrl_opclass.sv
// ctrl_opclass: combinational RV32I opcode to instruction-class decoder
module ctrl_opclass
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       valid
);
  assign op_class = opcode == OP_R      ? CL_R      :
                    opcode == OP_IALU   ? CL_IALU   :
                    opcode == OP_LOAD   ? CL_LOAD   :
                    opcode == OP_STORE  ? CL_STORE  :
                    opcode == OP_BRANCH ? CL_BRANCH : CL_NONE;
  assign valid = op_class != CL_NONE;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM with retired-instruction counter.
// Define MEM_WAIT_EN to stall FETCH and MEMORY until MemReady.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [6:0]       OpCode,
  input  logic             Zero,
`ifdef MEM_WAIT_EN
  input  logic             MemReady,
`endif
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             InstrDone,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetireCnt
);
  state_t    state;
  op_class_t cls, dec_cls;
  logic      dec_valid, mem_ok;
  logic      in_f, in_d, in_e, in_m, in_w, is_br, is_ld, is_st, is_alu;
  ctrl_opclass u_opclass (.opcode(OpCode), .op_class(dec_cls), .valid(dec_valid));
`ifdef MEM_WAIT_EN
  assign mem_ok = MemReady;
`else
  assign mem_ok = 1'b1;
`endif
  always_ff @(posedge clock or negedge Reset)
    if (!Reset) begin
      state     <= FETCH;
      cls       <= CL_NONE;
      Illegal   <= 1'b0;
      RetireCnt <= '0;
    end else begin
      RetireCnt <= RetireCnt + CNT_W'(InstrDone);
      case (state)
        FETCH:     state <= mem_ok ? DECODE : FETCH;
        DECODE: begin
          cls     <= dec_cls;
          state   <= dec_valid ? EXECUTE : TRAP_ON_ILLEGAL ? TRAP : FETCH;
          Illegal <= Illegal | (!dec_valid && TRAP_ON_ILLEGAL);
        end
        EXECUTE:   state <= is_br ? FETCH : (is_ld || is_st) ? MEMORY : WRITEBACK;
        MEMORY:    state <= !mem_ok ? MEMORY : is_ld ? WRITEBACK : FETCH;
        WRITEBACK: state <= FETCH;
        default:   state <= TRAP;
      endcase
    end
  // Reset gates FETCH so every enable is low while reset is held
  assign in_f   = Reset && state == FETCH;
  assign in_d   = state == DECODE;
  assign in_e   = state == EXECUTE;
  assign in_m   = state == MEMORY;
  assign in_w   = state == WRITEBACK;
  assign is_br  = cls == CL_BRANCH;
  assign is_ld  = cls == CL_LOAD;
  assign is_st  = cls == CL_STORE;
  assign is_alu = cls == CL_R || cls == CL_IALU;
  assign PCWrite   = (in_f && mem_ok) || (in_e && is_br && Zero);
  assign PCSrc     = in_e && is_br;
  assign IRWrite   = in_f && mem_ok;
  assign MemRead   = in_f || (in_m && is_ld);
  assign MemWrite  = in_m && is_st;
  assign RegWrite  = in_w;
  assign MemtoReg  = in_w && is_ld;
  assign ALUSrc    = in_e && (cls == CL_IALU || is_ld || is_st);
  assign ALUOp     = !in_e ? ALU_ADD : is_br ? ALU_SUB : is_alu ? ALU_FUNCT : ALU_ADD;
  assign InstrDone = (in_d && !dec_valid && !TRAP_ON_ILLEGAL) || (in_e && is_br) ||
                     (in_m && is_st && mem_ok) || in_w;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle timeline model of instruction phases plus literal latency/count checks
module tb_multicycle_ctrl;
  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, memto_reg, alu_src, instr_done, illegal;
  logic [1:0] alu_op;
  logic [2:0] retire_cnt;
`ifdef MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif
  int          tests = 0, fails = 0;
  bit          checking = 1'b0;
  logic [11:0] exp_v = '0, act_v;
  logic [2:0]  exp_cnt = '0, model_cnt = '0;
  int          cur_k = 0, done_at = 0;

  multicycle_ctrl #(.CNT_W(3), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .Reset(rst_n), .OpCode(opcode), .Zero(zero),
`ifdef MEM_WAIT_EN
    .MemReady(mem_ready),
`endif
    .PCWrite(pc_write), .PCSrc(pc_src), .IRWrite(ir_write), .MemRead(mem_read),
    .MemWrite(mem_write), .RegWrite(reg_write), .MemtoReg(memto_reg), .ALUSrc(alu_src),
    .ALUOp(alu_op), .InstrDone(instr_done), .Illegal(illegal), .RetireCnt(retire_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // kinds: 0 R, 1 IALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal
  function automatic int kind_of(input logic [6:0] op);
    return op == 7'b0110011 ? 0 : op == 7'b0010011 ? 1 : op == 7'b0000011 ? 2 :
           op == 7'b0100011 ? 3 : op == 7'b1100011 ? 4 : 5;
  endfunction

  function automatic int latency(input int kind);
    return kind == 4 ? 3 : kind == 2 ? 5 : 4;
  endfunction

  // bit map: 11 PCWrite 10 PCSrc 9 IRWrite 8 MemRead 7 MemWrite 6 RegWrite 5 MemtoReg 4 ALUSrc 3:2 ALUOp 1 InstrDone 0 Illegal
  function automatic logic [11:0] exp_vec(input int kind, input int k, input bit z);
    logic [11:0] v = '0;
    if (k == 1) begin v[11] = 1; v[9] = 1; v[8] = 1; end
    if (k == 3) begin
      if (kind <= 1) v[3:2] = 2'b10;
      if (kind >= 1 && kind <= 3) v[4] = 1;
      if (kind == 4) begin v[3:2] = 2'b01; v[10] = 1; v[11] = z; v[1] = 1; end
    end
    if (k == 4) begin
      if (kind <= 1) begin v[6] = 1; v[1] = 1; end
      if (kind == 2) v[8] = 1;
      if (kind == 3) begin v[7] = 1; v[1] = 1; end
    end
    if (k == 5 && kind == 2) begin v[6] = 1; v[5] = 1; v[1] = 1; end
    if (kind == 5 && k >= 3) v[0] = 1;
    return v;
  endfunction

  always @(negedge clock) if (checking) begin
    act_v = {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, memto_reg, alu_src, alu_op, instr_done, illegal};
    chk($sformatf("outputs k=%0d", cur_k), 32'(act_v), 32'(exp_v));
    chk($sformatf("retire_cnt k=%0d", cur_k), 32'(retire_cnt), 32'(exp_cnt));
    if (instr_done) done_at = cur_k;
  end

  task automatic run_instr(input logic [6:0] op, input bit z, input int ncyc, input int fwait);
    int kind, len;
    kind = kind_of(op);
    len = ncyc > 0 ? ncyc : latency(kind);
    done_at = 0;
    for (int w = 1; w <= fwait; w++) begin
`ifdef MEM_WAIT_EN
      mem_ready = 1'b0;
`endif
      opcode = op; zero = z; cur_k = w;
      exp_v = 12'h100; exp_cnt = model_cnt; checking = 1'b1;
      @(posedge clock); #1;
    end
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    for (int k = 1; k <= len; k++) begin
      opcode = op; zero = z; cur_k = k + fwait;
      exp_v = exp_vec(kind, k, z); exp_cnt = model_cnt; checking = 1'b1;
      @(posedge clock); #1;
    end
    if (ncyc == 0 && kind != 5) model_cnt = model_cnt + 3'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_cnt = '0; exp_v = '0; exp_cnt = '0; cur_k = 0; checking = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    chk("reset Illegal", 32'(illegal), 0);
    chk("reset MemRead", 32'(mem_read), 0);
    chk("reset RetireCnt", 32'(retire_cnt), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    run_instr(7'b0110011, 1'b0, 0, 0);
    chk("R done cycle", done_at, 4);
    chk("R RetireCnt", 32'(retire_cnt), 1);
    run_instr(7'b0000011, 1'b0, 0, 0);
    chk("LOAD done cycle", done_at, 5);
    run_instr(7'b1100011, 1'b1, 0, 0);
    chk("BR z1 done cycle", done_at, 3);
    run_instr(7'b1100011, 1'b0, 0, 0);
    chk("BR z0 done cycle", done_at, 3);
    chk("BR RetireCnt", 32'(retire_cnt), 4);
    run_instr(7'b0010011, 1'b0, 0, 0);
    chk("IALU done cycle", done_at, 4);
    run_instr(7'b0100011, 1'b0, 0, 0);
    chk("STORE done cycle", done_at, 4);
    run_instr(7'b0110011, 1'b0, 0, 0);
    run_instr(7'b0110011, 1'b0, 0, 0);
    chk("wrap RetireCnt", 32'(retire_cnt), 0);
    run_instr(7'b0110011, 1'b0, 0, 0);
    chk("post-wrap RetireCnt", 32'(retire_cnt), 1);
    do_reset();
    run_instr(7'b0100011, 1'b0, 3, 0);
    opcode = 7'b0100011; exp_v = exp_vec(3, 4, 1'b0); exp_cnt = model_cnt; cur_k = 4;
    @(negedge clock); #2;
    chk("STORE MEMORY MemWrite", 32'(mem_write), 1);
    rst_n = 1'b0; #1;
    chk("abort MemWrite", 32'(mem_write), 0);
    chk("abort RetireCnt", 32'(retire_cnt), 0);
    exp_v = '0; exp_cnt = '0;
    @(posedge clock); #1;
    rst_n = 1'b1; model_cnt = '0;
    run_instr(7'b0110011, 1'b0, 0, 0);
    chk("restart RetireCnt", 32'(retire_cnt), 1);
    run_instr(7'b1111111, 1'b0, 12, 0);
    chk("trap Illegal", 32'(illegal), 1);
    chk("trap RetireCnt", 32'(retire_cnt), 1);
    do_reset();
    #1;
    chk("post-trap Illegal", 32'(illegal), 0);
    chk("post-trap fetch MemRead", 32'(mem_read), 1);
    chk("post-trap fetch IRWrite", 32'(ir_write), 1);
    run_instr(7'b0110011, 1'b0, 0, 0);
    chk("post-trap R RetireCnt", 32'(retire_cnt), 1);
`ifdef MEM_WAIT_EN
    run_instr(7'b0110011, 1'b0, 0, 3);
    chk("wait R done cycle", done_at, 7);
    chk("wait R RetireCnt", 32'(retire_cnt), 2);
`endif
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
